// File: rtl/serial_logic_pkg.sv
// Shared types and the single NAND primitive for the bit-serial logic unit.
// Imported by serial_logic_bit_op and serial_logic16.
package serial_logic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_NAND = 2'b01,
        OP_OR   = 2'b10,
        OP_XOR  = 2'b11
    } op_t;

    function automatic logic nand2(input logic x, input logic y);
        return ~(x & y);
    endfunction

endpackage

// File: rtl/serial_logic16_if.sv
// Operand/result handshake bundle for serial_logic16.
// The master side issues operands and consumes results; the slave side is the unit.
interface serial_logic16_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             busy;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, out, busy
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, out, busy
    );
endinterface

// File: rtl/serial_logic_bit_op.sv
// Single-bit NAND-only operator evaluator. OR/XOR paths exist only when
// SERIAL_LOGIC_OR_XOR_EN is defined; otherwise op[1] is ignored.
module serial_logic_bit_op
    import serial_logic_pkg::*;
(
    input  logic [1:0] op,
    input  logic       a_bit,
    input  logic       b_bit,
    output logic       r
);

    logic n_ab;
    logic and_r;

    assign n_ab  = nand2(a_bit, b_bit);
    assign and_r = nand2(n_ab, n_ab);

`ifdef SERIAL_LOGIC_OR_XOR_EN
    logic or_r;
    logic xor_r;

    assign or_r  = nand2(nand2(a_bit, a_bit), nand2(b_bit, b_bit));
    // Four-NAND XOR reuses the shared first-stage n_ab.
    assign xor_r = nand2(nand2(a_bit, n_ab), nand2(b_bit, n_ab));

    always_comb begin
        // NOTE: default assignment first so every path drives r and no latch is inferred.
        r = and_r;
        case (op_t'(op))
            OP_AND:  r = and_r;
            OP_NAND: r = n_ab;
            OP_OR:   r = or_r;
            OP_XOR:  r = xor_r;
            default: r = and_r;
        endcase
    end
`else
    logic unused_op_hi;

    assign unused_op_hi = op[1];
    assign r            = op[0] ? n_ab : and_r;
`endif

endmodule

// File: rtl/serial_logic16.sv
// Bit-serial 16-bit logic unit: one result bit per clock through a NAND-only
// evaluator. Optional OR/XOR ops are enabled by SERIAL_LOGIC_OR_XOR_EN.
module serial_logic16
    import serial_logic_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_logic16_if.slave  bus
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] out_q;
    logic             out_valid_q;
    logic             in_ready_q;
    logic             busy_q;
    logic             r_bit;
    logic [WIDTH-1:0] res_next;

    serial_logic_bit_op u_bit_op (
        .op    (op_q),
        .a_bit (a_sh[0]),
        .b_bit (b_sh[0]),
        .r     (r_bit)
    );

    // LSB-first evaluation, so each new bit enters at the MSB and the word
    // lands aligned after WIDTH shifts.
    assign res_next = {r_bit, res_sh[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the shift registers are plain flops, so they take the reset
            // value along with the control state rather than being left undefined.
            state       <= IDLE;
            cnt         <= '0;
            a_sh        <= '0;
            b_sh        <= '0;
            res_sh      <= '0;
            op_q        <= OP_AND;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        a_sh       <= bus.a;
                        b_sh       <= bus.b;
                        op_q       <= bus.op;
                        cnt        <= '0;
                        state      <= SHIFT;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                SHIFT: begin
                    res_sh <= res_next;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state       <= DONE;
                        out_q       <= res_next;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = out_q;
    assign bus.busy      = busy_q;

endmodule

// File: doc/serial_logic16.md
Name: serial_logic16

Overview:
- Sequential, bit-serial counterpart of the team's parallel 16-bit NAND-built gate arrays.
- Accepts a pair of 16-bit operands and an opcode through a valid/ready handshake.
- Computes the bitwise result one bit per clock, using only 2-input NAND primitives.
- Returns the 16-bit word through a second valid/ready handshake.
- Sits between the operand registers and the ALU result bus for area-constrained CPU builds.

Parameters:
- WIDTH, 16, operand/result width in bits (legal range 2..64).
- CNT_W, $clog2(WIDTH), bit-counter width (derived; do not override).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair and op are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand a.
- b  input  WIDTH  operand b.
- op  input  2  operation select.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts result.
- out  output  WIDTH  result word.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset (async, rst_n low):
  - State goes to IDLE; counter, operand and result shift registers clear to 0.
  - out=0, out_valid=0.
  - in_ready=1 once in IDLE, i.e. immediately after reset releases.
- States:
  - IDLE: in_ready=1, busy=0. On in_valid&&in_ready, capture a, b, op; clear counter; go to SHIFT.
  - SHIFT: in_ready=0, busy=1. Each cycle, compute r = f(a_sh[0], b_sh[0]) and shift it into result MSB; shift a_sh and b_sh right by 1; increment counter. When counter==WIDTH-1, take the last bit and go to DONE.
  - DONE: out_valid=1, out=result, busy=1. On out_ready, go to IDLE with out_valid=0. out retains its last value.
- Latency: out_valid rises exactly WIDTH clocks after the accepting edge. With WIDTH=16, accept at edge 0 gives out_valid high after edge 16.
- Throughput: one word per WIDTH+2 cycles with out_ready held high; there is no overlap.
- Operations (nand2(x,y)=~(x&y) is the only gate used):
  - op 00: AND = nand2(n,n), where n=nand2(a,b).
  - op 01: NAND = n.
- Backpressure: while out_ready is low in DONE, out and out_valid hold stable indefinitely. in_valid is ignored.
- Inputs a, b, op may change freely after the accepting edge; captured copies are used.
- in_valid asserted in SHIFT/DONE is not accepted and causes no side effect.
- Reset mid-SHIFT or mid-DONE: the transaction is aborted and all outputs return to reset values asynchronously.

Optional Feature:
- Macro: SERIAL_LOGIC_OR_XOR_EN.
- Defined:
  - op 10: OR = nand2(nand2(a,a), nand2(b,b)).
  - op 11: XOR = classic four-NAND structure.
- Undefined: op[1] is ignored, so 10 behaves as AND and 11 behaves as NAND. No OR/XOR logic is synthesised.

Decomposition:
- Shared package serial_logic_pkg:
  - State enum (IDLE, SHIFT, DONE).
  - Op encodings (OP_AND=2'b00, OP_NAND=2'b01, OP_OR=2'b10, OP_XOR=2'b11).
  - nand2 function.
- One sub-module: serial_logic_bit_op. Purely combinational single-bit op evaluator (op, a_bit, b_bit -> r), NAND-only, holding the macro-guarded OR/XOR paths.
- The FSM, counter and shift registers stay in the top.

Test Plan:
- AND: a=16'hFFFF, b=16'h00FF, op=00, out_ready=1 -> out_valid after 16 clocks, out=16'h00FF; in_ready returns high 2 cycles later.
- NAND with backpressure: a=16'hF0F0, b=16'hFF00, op=01, out_ready low for 5 cycles -> out=16'h0FFF held stable with out_valid=1 for all 5; completes on the first out_ready.
- Reset mid-operation: assert rst_n=0 at shift cycle 7 of a=16'h1234 -> out=0, out_valid=0 immediately. The next transaction a=16'hAAAA, b=16'hFFFF, AND gives 16'hAAAA.
- Back-to-back with in_valid held high: two words 16'h00FF&16'h0F0F, then 16'hFFFF&16'h8001 -> 16'h000F, then 16'h8001. Second accept occurs only after the first handshake; no duplicate accept.
- Macro defined:
  - OR: a=16'hF000, b=16'h000F -> 16'hF00F.
  - XOR: a=16'hFFFF, b=16'h0F0F -> 16'hF0F0.
- Macro undefined: the same OR stimulus with op=10 -> 16'h0000 (AND).
